// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, word-organised data RAM with byte/half/word
// access, load extension and the MEM/WB register feeding Writeback.
// Optional build macro MEM_MISALIGN_CHECK_EN: flags misaligned half/word
// accesses, suppresses misaligned stores and kills misaligned loads.
module memory_stage #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 1024,
   localparam int ABITS = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             StallM,
   input  logic             FlushM,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic [WIDTH-1:0] WriteDataE,
   input  logic [WIDTH-1:0] PCPlus4E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic [2:0]       Funct3E,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [4:0]       RdM,
   output logic             RegWriteM,
   output logic [WIDTH-1:0] ALUResultW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic [WIDTH-1:0] PCPlus4W,
   output logic [4:0]       RdW,
   output logic             RegWriteW,
   output logic [1:0]       ResultSrcW,
   output logic             MisalignM
);

   // EX/MEM fields
   logic [WIDTH-1:0] r_alu_m, r_wd_m, r_pc4_m;
   logic [4:0]       r_rd_m;
   logic             r_regwr_m, r_memwr_m;
   logic [1:0]       r_rsrc_m;
   logic [2:0]       r_f3_m;

   // MEM/WB fields
   logic [WIDTH-1:0] r_alu_w, r_rdata_w, r_pc4_w;
   logic [4:0]       r_rd_w;
   logic             r_regwr_w;
   logic [1:0]       r_rsrc_w;

   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [ABITS-1:0] w_idx;
   logic [WIDTH-1:0] w_rword;
   logic [WIDTH-1:0] w_ldata;
   logic [WIDTH-1:0] w_sword;
   logic             w_st_legal;
   logic             w_st_en;
   logic             w_mis;
   logic             w_unused;

   // Sign/zero extension of the addressed byte/half for the load code
   function automatic logic [WIDTH-1:0] f_extend(input logic [2:0] f3,
                                                 input logic [WIDTH-1:0] word,
                                                 input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*off +: 8];
      h = word[16*off[1] +: 16];
      case (f3)
         3'b000:  f_extend = {{(WIDTH-8){b[7]}}, b};
         3'b001:  f_extend = {{(WIDTH-16){h[15]}}, h};
         3'b010:  f_extend = word;
         3'b100:  f_extend = {{(WIDTH-8){1'b0}}, b};
         3'b101:  f_extend = {{(WIDTH-16){1'b0}}, h};
         default: f_extend = '0;
      endcase
   endfunction

   // Merge store data into the old word according to the store size
   function automatic logic [WIDTH-1:0] f_merge(input logic [2:0] f3,
                                                input logic [WIDTH-1:0] old,
                                                input logic [WIDTH-1:0] wd,
                                                input logic [1:0] off);
      f_merge = old;
      case (f3)
         3'b000:  f_merge[8*off +: 8]       = wd[7:0];
         3'b001:  f_merge[16*off[1] +: 16]  = wd[15:0];
         3'b010:  f_merge                   = wd;
         default: f_merge                   = old;
      endcase
   endfunction

   assign w_idx   = r_alu_m[ABITS+1:2];
   assign w_rword = r_mem[w_idx];
   assign w_ldata = f_extend(r_f3_m, w_rword, r_alu_m[1:0]);
   assign w_sword = f_merge(r_f3_m, w_rword, r_wd_m, r_alu_m[1:0]);

   // Upper address bits beyond the RAM wrap modulo DEPTH*4
   assign w_unused = &{1'b0, r_alu_m[WIDTH-1:ABITS+2]};

`ifdef MEM_MISALIGN_CHECK_EN
   // Misaligned half/word access by a store or a load
   always_comb begin
      w_mis = 1'b0;
      if (r_memwr_m || (r_rsrc_m == 2'b01)) begin
         if ((r_f3_m[1:0] == 2'b01) && r_alu_m[0])
            w_mis = 1'b1;
         else if ((r_f3_m[1:0] == 2'b10) && (r_alu_m[1:0] != 2'b00))
            w_mis = 1'b1;
      end
   end
`else
   assign w_mis = 1'b0;
`endif

   // Only the three defined store sizes write; the store lands as it leaves M
   assign w_st_legal = (r_f3_m == 3'b000) || (r_f3_m == 3'b001) || (r_f3_m == 3'b010);
   assign w_st_en    = r_memwr_m && !StallM && !rst && w_st_legal && !w_mis;

   // EX/MEM register: flush beats stall, stall holds
   always_ff @(posedge clk) begin
      if (rst || FlushM) begin
         r_alu_m   <= '0;
         r_wd_m    <= '0;
         r_pc4_m   <= '0;
         r_rd_m    <= '0;
         r_regwr_m <= 1'b0;
         r_memwr_m <= 1'b0;
         r_rsrc_m  <= '0;
         r_f3_m    <= '0;
      end else if (!StallM) begin
         r_alu_m   <= ALUResultE;
         r_wd_m    <= WriteDataE;
         r_pc4_m   <= PCPlus4E;
         r_rd_m    <= RdE;
         r_regwr_m <= RegWriteE;
         r_memwr_m <= MemWriteE;
         r_rsrc_m  <= ResultSrcE;
         r_f3_m    <= Funct3E;
      end
   end

   // Data RAM write port (contents are not reset)
   always_ff @(posedge clk) begin
      if (w_st_en)
         r_mem[w_idx] <= w_sword;
   end

   // MEM/WB register: a stalled M stage sends a bubble to W
   always_ff @(posedge clk) begin
      if (rst || StallM) begin
         r_alu_w   <= '0;
         r_rdata_w <= '0;
         r_pc4_w   <= '0;
         r_rd_w    <= '0;
         r_regwr_w <= 1'b0;
         r_rsrc_w  <= '0;
      end else begin
         r_alu_w   <= r_alu_m;
         r_rdata_w <= w_mis ? '0 : w_ldata;
         r_pc4_w   <= r_pc4_m;
         r_rd_w    <= r_rd_m;
         r_regwr_w <= r_regwr_m && !w_mis;
         r_rsrc_w  <= r_rsrc_m;
      end
   end

   assign ALUResultM = r_alu_m;
   assign RdM        = r_rd_m;
   assign RegWriteM  = r_regwr_m;
   assign MisalignM  = w_mis;
   assign ALUResultW = r_alu_w;
   assign ReadDataW  = r_rdata_w;
   assign PCPlus4W   = r_pc4_w;
   assign RdW        = r_rd_w;
   assign RegWriteW  = r_regwr_w;
   assign ResultSrcW = r_rsrc_w;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of single-instruction vectors with
// hand-computed results, plus sequences for flush, stall and reset.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst, StallM, FlushM;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [4:0]  RdE;
   logic        RegWriteE, MemWriteE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  Funct3E;
   logic [31:0] ALUResultM, ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdM, RdW;
   logic        RegWriteM, RegWriteW, MisalignM;
   logic [1:0]  ResultSrcW;

   int checks = 0;
   int errors = 0;

   memory_stage dut (
      .clk(clk), .rst(rst), .StallM(StallM), .FlushM(FlushM),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
      .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .MisalignM(MisalignM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        rw;
      logic        mw;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic        chk;
      logic [31:0] exp_rd;
      logic        exp_rw;
      logic        exp_mis;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic [31:0] alu, logic [31:0] wd, logic [31:0] pc4,
                               logic [4:0] rd, logic rw, logic mw, logic [1:0] rs,
                               logic [2:0] f3, logic chk, logic [31:0] exp_rd,
                               logic exp_rw, logic exp_mis);
      vec_t v;
      v.alu = alu; v.wd = wd; v.pc4 = pc4; v.rd = rd; v.rw = rw; v.mw = mw;
      v.rs = rs; v.f3 = f3; v.chk = chk; v.exp_rd = exp_rd;
      v.exp_rw = exp_rw; v.exp_mis = exp_mis;
      return v;
   endfunction

   function automatic vec_t ld(logic [31:0] a, logic [2:0] f3, logic [4:0] rd, logic [31:0] e);
      return mk(a, 32'h0, 32'h0, rd, 1'b1, 1'b0, 2'b01, f3, 1'b1, e, 1'b1, 1'b0);
   endfunction

   function automatic vec_t st(logic [31:0] a, logic [2:0] f3, logic [31:0] d);
      return mk(a, d, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, f3, 1'b0, 32'h0, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive_e(input vec_t v);
      ALUResultE = v.alu; WriteDataE = v.wd; PCPlus4E = v.pc4; RdE = v.rd;
      RegWriteE = v.rw; MemWriteE = v.mw; ResultSrcE = v.rs; Funct3E = v.f3;
   endtask

   task automatic drive_nop();
      drive_e(mk(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ALUResultM"}, ALUResultM, 32'h0);
      chk({tag, "_RdM"}, {27'h0, RdM}, 32'h0);
      chk({tag, "_RegWriteM"}, {31'h0, RegWriteM}, 32'h0);
      chk({tag, "_ALUResultW"}, ALUResultW, 32'h0);
      chk({tag, "_ReadDataW"}, ReadDataW, 32'h0);
      chk({tag, "_PCPlus4W"}, PCPlus4W, 32'h0);
      chk({tag, "_RdW"}, {27'h0, RdW}, 32'h0);
      chk({tag, "_RegWriteW"}, {31'h0, RegWriteW}, 32'h0);
      chk({tag, "_ResultSrcW"}, {30'h0, ResultSrcW}, 32'h0);
      chk({tag, "_MisalignM"}, {31'h0, MisalignM}, 32'h0);
   endtask

   // One instruction through E, M and W with bubbles behind it
   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      drive_e(v);
      @(posedge clk); #1;
      drive_nop();
      chk($sformatf("v%0d_ALUResultM", idx), ALUResultM, v.alu);
      chk($sformatf("v%0d_RdM", idx), {27'h0, RdM}, {27'h0, v.rd});
      chk($sformatf("v%0d_RegWriteM", idx), {31'h0, RegWriteM}, {31'h0, v.rw});
      chk($sformatf("v%0d_MisalignM", idx), {31'h0, MisalignM}, {31'h0, v.exp_mis});
      @(posedge clk); #1;
      chk($sformatf("v%0d_RegWriteW", idx), {31'h0, RegWriteW}, {31'h0, v.exp_rw});
      chk($sformatf("v%0d_ResultSrcW", idx), {30'h0, ResultSrcW}, {30'h0, v.rs});
      chk($sformatf("v%0d_RdW", idx), {27'h0, RdW}, {27'h0, v.rd});
      chk($sformatf("v%0d_ALUResultW", idx), ALUResultW, v.alu);
      chk($sformatf("v%0d_PCPlus4W", idx), PCPlus4W, v.pc4);
      if (v.chk)
         chk($sformatf("v%0d_ReadDataW", idx), ReadDataW, v.exp_rd);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; StallM = 1'b0; FlushM = 1'b0;
      drive_nop();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // Vector table
      vq.push_back(st(32'h10, 3'b010, 32'hDEADBEEF));
      vq.push_back(ld(32'h10, 3'b010, 5'd5, 32'hDEADBEEF));
      vq.push_back(st(32'h13, 3'b000, 32'h00000080));
      vq.push_back(ld(32'h13, 3'b000, 5'd6, 32'hFFFFFF80));
      vq.push_back(ld(32'h13, 3'b100, 5'd7, 32'h00000080));
      vq.push_back(ld(32'h10, 3'b010, 5'd8, 32'h80ADBEEF));
      vq.push_back(ld(32'h11, 3'b000, 5'd9, 32'hFFFFFFBE));
      vq.push_back(ld(32'h10, 3'b001, 5'd10, 32'hFFFFBEEF));
      vq.push_back(ld(32'h10, 3'b011, 5'd11, 32'h00000000));
      vq.push_back(ld(32'h10, 3'b110, 5'd12, 32'h00000000));
      vq.push_back(st(32'h20, 3'b010, 32'h11223344));
      vq.push_back(st(32'h22, 3'b001, 32'hFFFF8001));
      vq.push_back(ld(32'h22, 3'b001, 5'd13, 32'hFFFF8001));
      vq.push_back(ld(32'h22, 3'b101, 5'd14, 32'h00008001));
      vq.push_back(ld(32'h20, 3'b010, 5'd15, 32'h80013344));
      vq.push_back(ld(32'h20, 3'b101, 5'd16, 32'h00003344));
      vq.push_back(mk(32'h12345678, 32'h0, 32'h100, 5'd17, 1'b1, 1'b0, 2'b00, 3'b000,
                      1'b0, 32'h0, 1'b1, 1'b0));
      vq.push_back(mk(32'h00000040, 32'h0, 32'h200, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000,
                      1'b0, 32'h0, 1'b1, 1'b0));
      vq.push_back(st(32'h1008, 3'b010, 32'hCAFEF00D));
      vq.push_back(ld(32'h8, 3'b010, 5'd18, 32'hCAFEF00D));
      vq.push_back(st(32'h8, 3'b111, 32'h00000000));
      vq.push_back(ld(32'h1008, 3'b010, 5'd19, 32'hCAFEF00D));
`ifdef MEM_MISALIGN_CHECK_EN
      vq.push_back(mk(32'h11, 32'h12345678, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00, 3'b010,
                      1'b0, 32'h0, 1'b0, 1'b1));
      vq.push_back(ld(32'h10, 3'b010, 5'd20, 32'h80ADBEEF));
      vq.push_back(mk(32'h21, 32'h0, 32'h0, 5'd21, 1'b1, 1'b0, 2'b01, 3'b001,
                      1'b1, 32'h0, 1'b0, 1'b1));
`else
      vq.push_back(ld(32'h12, 3'b010, 5'd20, 32'h80ADBEEF));
      vq.push_back(ld(32'h23, 3'b001, 5'd21, 32'hFFFF8001));
`endif

      foreach (vq[i]) run_vec(vq[i], i);

      // Flushed store never reaches the RAM
      run_vec(st(32'h30, 3'b010, 32'h01020304), 100);
      @(negedge clk);
      drive_e(st(32'h30, 3'b010, 32'hFFFFFFFF));
      FlushM = 1'b1;
      @(posedge clk); #1;
      FlushM = 1'b0;
      drive_nop();
      chk("flush_ALUResultM", ALUResultM, 32'h0);
      chk("flush_RegWriteM", {31'h0, RegWriteM}, 32'h0);
      @(posedge clk); #1;
      run_vec(ld(32'h30, 3'b010, 5'd22, 32'h01020304), 101);

      // Stalled store held in M for three cycles, W gets bubbles
      @(negedge clk);
      drive_e(mk(32'h77, 32'h0, 32'h300, 5'd9, 1'b1, 1'b0, 2'b00, 3'b000,
                 1'b0, 32'h0, 1'b1, 1'b0));
      @(posedge clk); #1;
      drive_e(st(32'h40, 3'b010, 32'hA5A55A5A));
      @(posedge clk); #1;
      chk("stall_pre_RegWriteW", {31'h0, RegWriteW}, 32'h1);
      chk("stall_pre_RdW", {27'h0, RdW}, 32'd9);
      StallM = 1'b1;
      drive_e(mk(32'h999, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 2'b00, 3'b000,
                 1'b0, 32'h0, 1'b1, 1'b0));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d_RegWriteW", k), {31'h0, RegWriteW}, 32'h0);
         chk($sformatf("stall%0d_ALUResultM", k), ALUResultM, 32'h40);
         chk($sformatf("stall%0d_RegWriteM", k), {31'h0, RegWriteM}, 32'h0);
      end
      StallM = 1'b0;
      drive_nop();
      @(posedge clk); #1;
      chk("stall_rel_ALUResultW", ALUResultW, 32'h40);
      chk("stall_rel_RegWriteW", {31'h0, RegWriteW}, 32'h0);
      chk("stall_rel_RegWriteM", {31'h0, RegWriteM}, 32'h0);
      @(posedge clk); #1;
      run_vec(ld(32'h40, 3'b010, 5'd23, 32'hA5A55A5A), 102);

      // Reset with a store in M and a register write in W
      run_vec(st(32'h50, 3'b010, 32'h11111111), 103);
      @(negedge clk);
      drive_e(mk(32'h66, 32'h0, 32'h44, 5'd3, 1'b1, 1'b0, 2'b00, 3'b000,
                 1'b0, 32'h0, 1'b1, 1'b0));
      @(posedge clk); #1;
      drive_e(st(32'h50, 3'b010, 32'h22222222));
      @(posedge clk); #1;
      chk("rst_pre_RegWriteW", {31'h0, RegWriteW}, 32'h1);
      rst = 1'b1;
      drive_nop();
      @(posedge clk); #1;
      rst = 1'b0;
      chk_all_zero("midrst");
      run_vec(ld(32'h50, 3'b010, 5'd24, 32'h11111111), 104);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
